// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared 32-bit alu; rsp_valid rises lat edges after accept
// (MUL_LAT for mul, ALU_LAT otherwise); the result is held until the owner takes it, and no new request is accepted meanwhile.

module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  opcode,
    output logic [31:0] c,
    output logic [2:0]  d
);
    logic [32:0] wide;
    logic [31:0] sra_res;

    assign sra_res = 32'($signed(a) >>> b[4:0]);

    // bit 32 carries the add carry-out / sub borrow; status is {zero, negative, carry}
    always_comb begin
        wide = '0;
        case (opcode)
            3'b000:  wide = {1'b0, a << b[4:0]};
            3'b001:  wide = {1'b0, sra_res};
            3'b010:  wide = {1'b0, a} + {1'b0, b};
            3'b011:  wide = {1'b0, a} - {1'b0, b};
            3'b100:  wide = {1'b0, a * b};
            3'b101:  wide = {1'b0, a & b};
            3'b110:  wide = {1'b0, a | b};
            default: wide = {1'b0, ~a};
        endcase
    end

    assign c = wide[31:0];
    assign d = {(wide[31:0] == 32'd0), wide[31], wide[32]};
endmodule

module alu_arbiter #(
    parameter int MUL_LAT = 4,
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [2:0]  req_op0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    input  logic [2:0]  req_op1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_c,
    output logic [2:0]  rsp_d,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam int MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT - 1);

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]     a_q, a_d, b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [1:0]      rsp_valid_q, rsp_valid_d;
    logic [31:0]     res_c_q, res_c_d;
    logic [2:0]      res_st_q, res_st_d;

    logic            win;
    logic            win_vld;
    logic [31:0]     sel_a, sel_b;
    logic [2:0]      sel_op;
    logic [31:0]     alu_c;
    logic [2:0]      alu_d;

    // On a tie the requester that did not finish most recently wins
    always_comb begin
        win = 1'b0;
        case (req_valid)
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_q;
            default: win = 1'b0;
        endcase
    end

    assign win_vld   = |req_valid;
    assign req_ready = (state_q == IDLE && win_vld) ? (win ? 2'b10 : 2'b01) : 2'b00;
    assign sel_a     = win ? req_a1  : req_a0;
    assign sel_b     = win ? req_b1  : req_b0;
    assign sel_op    = win ? req_op1 : req_op0;

    alu u_alu (
        .a      (a_q),
        .b      (b_q),
        .opcode (op_q),
        .c      (alu_c),
        .d      (alu_d)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        owner_d     = owner_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        res_c_d     = res_c_q;
        res_st_d    = res_st_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    op_d    = sel_op;
                    owner_d = win;
                    cnt_d   = (sel_op == 3'b100) ? MUL_CNT : ALU_CNT;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    res_c_d     = alu_c;
                    res_st_d    = alu_d;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = 2'b00;
                    last_d      = owner_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            rsp_valid_q <= 2'b00;
            res_c_q     <= '0;
            res_st_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            res_c_q     <= res_c_d;
            res_st_q    <= res_st_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_c     = res_c_q;
    assign rsp_d     = res_st_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single operations plus tie, backpressure, fairness and reset sequences.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1, rsp_c;
    logic [2:0]  req_op0, req_op1, rsp_d;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    alu_arbiter #(.MUL_LAT(4), .ALU_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_op0   (req_op0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_op1   (req_op1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_d     (rsp_d),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          req;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] c;
        logic [2:0]  d;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Both requesters must never be granted in the same cycle
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (req_ready == 2'b11) begin
                fails++;
                $display("FAIL req_ready_onehot: got %b", req_ready);
            end
        end
    end

    // Called right after an accept edge; returns the number of edges until rsp_valid appears
    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            chk("req_ready_busy", 32'(req_ready), 32'd0);
        end while (rsp_valid == 2'b00 && n < 40);
        if (n >= 40) $display("FAIL rsp_timeout: no response within %0d edges", n);
    endtask

    // Entered at a negedge with the request already presented; leaves at a negedge in IDLE
    task automatic serve(input int own, input logic [31:0] ec, input logic [2:0] ed,
                         input int elat, input bit drop);
        int n;
        logic [1:0] oh;
        oh = (own == 1) ? 2'b10 : 2'b01;
        #1;
        chk("req_ready_grant", 32'(req_ready), 32'(oh));
        @(posedge clk);
        #1;
        if (drop) req_valid[own] = 1'b0;
        wait_rsp(n);
        chk("latency", n, elat);
        chk("rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("rsp_c", rsp_c, ec);
        chk("rsp_d", 32'(rsp_d), 32'(ed));
        chk("busy_resp", 32'(busy), 32'd1);
        rsp_ready = oh;
        @(posedge clk);
        #1;
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("rsp_valid_clear", 32'(rsp_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("last", 32'(dut.last_q), own);
    endtask

    task automatic do_op(input vec_t v);
        if (v.req == 0) begin
            req_a0 = v.a; req_b0 = v.b; req_op0 = v.op;
        end else begin
            req_a1 = v.a; req_b1 = v.b; req_op1 = v.op;
        end
        req_valid[v.req] = 1'b1;
        serve(v.req, v.c, v.d, v.lat, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        // req, a, b, op, expected c, expected d {zero,neg,carry}, latency
        vecs[0]  = '{0, 32'd5,         32'd7,         3'b010, 32'd12,        3'b000, 1};
        vecs[1]  = '{1, 32'd10,        32'd3,         3'b011, 32'd7,         3'b000, 1};
        vecs[2]  = '{0, 32'd3,         32'd10,        3'b011, 32'hFFFF_FFF9, 3'b011, 1};
        vecs[3]  = '{1, 32'd9,         32'hFFFF_FFF3, 3'b100, 32'hFFFF_FF8B, 3'b010, 4};
        vecs[4]  = '{0, 32'hFFFF_FFFF, 32'd1,         3'b010, 32'd0,         3'b101, 1};
        vecs[5]  = '{1, 32'h0000_F0F0, 32'h0000_FF00, 3'b101, 32'h0000_F000, 3'b000, 1};
        vecs[6]  = '{0, 32'h0000_000F, 32'h0000_00F0, 3'b110, 32'h0000_00FF, 3'b000, 1};
        vecs[7]  = '{1, 32'd0,         32'd123,       3'b111, 32'hFFFF_FFFF, 3'b010, 1};
        vecs[8]  = '{0, 32'd1,         32'd4,         3'b000, 32'd16,        3'b000, 1};
        vecs[9]  = '{1, 32'h8000_0000, 32'd4,         3'b001, 32'hF800_0000, 3'b010, 1};
        vecs[10] = '{0, 32'd3,         32'd5,         3'b100, 32'd15,        3'b000, 4};

        rst = 1'b0;
        rsp_ready = 2'b00;
        req_a0 = 32'd1;  req_b0 = 32'd1; req_op0 = 3'b010;
        req_a1 = 32'd10; req_b1 = 32'd3; req_op1 = 3'b011;
        req_valid = 2'b11;
        #2 rst = 1'b1;

        // Reset state, then tie from the first cycle: r0 first, then r1
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_c", rsp_c, 32'd0);
        chk("rst_rsp_d", 32'(rsp_d), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last", 32'(dut.last_q), 32'd1);
        rst = 1'b0;
        serve(0, 32'd2, 3'b000, 1, 1'b1);
        serve(1, 32'd7, 3'b000, 1, 1'b1);

        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            do_op(v);
        end

        // Backpressure: r0 result held while r1 waits; non-owner ready ignored
        req_a0 = 32'd5; req_b0 = 32'd7; req_op0 = 3'b010;
        req_a1 = 32'd1; req_b1 = 32'd1; req_op1 = 3'b010;
        req_valid = 2'b01;
        #1;
        chk("bp_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        begin
            int n;
            wait_rsp(n);
            chk("bp_latency", n, 1);
        end
        for (int k = 0; k < 7; k++) begin
            if (k == 5) rsp_ready = 2'b10;
            @(posedge clk);
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_c", rsp_c, 32'd12);
            chk("bp_rsp_d", 32'(rsp_d), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 2'b01;
        @(posedge clk);
        #1;
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("bp_release", 32'(rsp_valid), 32'd0);
        serve(1, 32'd2, 3'b000, 1, 1'b1);

        // Fairness: both continuously valid; last is 1 so r0 goes first
        req_a0 = 32'd1;  req_b0 = 32'd2; req_op0 = 3'b010;
        req_a1 = 32'd50; req_b1 = 32'd8; req_op1 = 3'b011;
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            serve(i % 2, (i % 2) ? 32'd42 : 32'd3, 3'b000, 1, 1'b0);
        end
        req_valid = 2'b00;

        // Reset during the second EXEC cycle of a mul
        req_a1 = 32'd9; req_b1 = 32'hFFFF_FFF3; req_op1 = 3'b100;
        req_valid = 2'b10;
        #1;
        chk("mr_grant", 32'(req_ready), 32'd2);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        chk("mr_busy_exec", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_rsp_c", rsp_c, 32'd0);
        chk("mr_rsp_d", 32'(rsp_d), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_last", 32'(dut.last_q), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
            chk("mr_idle", 32'(busy), 32'd0);
        end
        v = '{0, 32'd5, 32'd7, 3'b010, 32'd12, 3'b000, 1};
        do_op(v);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer for the shared 32-bit `alu` datapath. Two requesters each present an operand pair and a 3-bit opcode through a valid/ready handshake. The block grants one request at a time and holds the operands stable at the `alu` inputs for a fixed, opcode-dependent number of cycles. It then registers the `alu` result and 3-bit status and returns them to the winning requester through a valid/ready response handshake. It sits between the instruction-issue logic and the single `alu` instance, which it instantiates internally.

## Interface
- `MUL_LAT`, default 4: cycles spent in EXEC for opcode 3'b100 (mul). Legal range is ≥1.
- `ALU_LAT`, default 1: cycles spent in EXEC for every other opcode. Legal range is ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 2: bit i means requester i has an operation pending.
- `req_ready` out 2: bit i means requester i's operation is accepted this cycle.
- `req_a0`, `req_b0` in 32: requester 0 operands.
- `req_op0` in 3: requester 0 opcode.
- `req_a1`, `req_b1` in 32: requester 1 operands.
- `req_op1` in 3: requester 1 opcode.
- `rsp_valid` out 2: one-hot; bit i means a result for requester i is present.
- `rsp_ready` in 2: bit i means requester i takes the result this cycle.
- `rsp_c` out 32: registered `alu` result c.
- `rsp_d` out 3: registered `alu` status d.
- `busy` out 1: high in EXEC or RESP.

## Operation
- Opcode encoding is the `alu` encoding:
  - 000 sla, 001 sra, 010 add, 011 sub
  - 100 mul, 101 and, 110 or, 111 not
  - The block does not decode or alter opcodes except to select latency.
- States and transitions:
  - IDLE: no operation in flight.
  - EXEC: operands and opcode held in registers driving `alu` a, b, opcode; `alu` output ignored until the last EXEC cycle.
  - RESP: result registered; waiting for the response handshake.
- Arbitration, evaluated only in IDLE:
  - If exactly one `req_valid` bit is set, that requester wins.
  - If both are set, the requester other than `last` wins.
  - `last` is a 1-bit register updated to the owner on each completed response handshake. Its reset value is 1, so requester 0 wins the first tie.
- `req_ready[i]` = (state==IDLE) & `req_valid[i]` & (winner==i). It is combinational and at most one bit is ever set.
- Accept edge (IDLE, `req_valid[i]` & `req_ready[i]`):
  - Latch the winner's a, b, op and `owner`=i.
  - Load `cnt` with lat−1, where lat = `MUL_LAT` if op==100, else `ALU_LAT`.
  - Go to EXEC.
- In EXEC: at each edge with `cnt`≠0, decrement `cnt`. At the edge with `cnt`==0, capture `alu` c→`rsp_c` and d→`rsp_d`, set `rsp_valid[owner]`, and go to RESP.
- In RESP: `rsp_valid[owner]` holds until `rsp_ready[owner]`. At that edge, clear `rsp_valid`, set `last`←`owner`, and go to IDLE. `rsp_ready` of the non-owner is ignored.
- `rsp_c` and `rsp_d` hold their last captured value after the handshake, until the next capture.
- `busy` = (state≠IDLE).

## Timing
- Reset values (asynchronous):
  - state IDLE, `rsp_valid`=00, `rsp_c`=0, `rsp_d`=0, `busy`=0, `last`=1, `cnt`=0.
  - `req_ready` follows its combinational rule, so it can be nonzero immediately after reset is released.
- Latency: accept at edge E0 → `rsp_valid` visible after edge E(lat).
  - With defaults: non-mul after E1, mul after E4.
- Minimum issue interval is lat+2 cycles: IDLE accept, lat EXEC cycles, then at least one RESP cycle. There is no accept in the same cycle as a response handshake.
- Requester inputs may change freely after their accept edge. Operands are never re-sampled.
- A requester that drops `req_valid` before being accepted loses nothing; no state changes.
- `rst` asserted in EXEC or RESP drops the operation: no response is delivered, and the block returns to IDLE with the reset values above.

## Test plan
- Single add: r0 sends a=5, b=7, op=010. Expect `req_ready`=01 in that cycle, `rsp_valid`=01 exactly 1 edge later, `rsp_c`=12, `busy`=1 through RESP.
- Tie after reset: both valid from the first cycle; r0 sends add 1+1, r1 sends sub 10−3. Expect r0 served first (`rsp_c`=2), then r1 (`rsp_c`=7), with no cycle where `req_ready`=11.
- Mul latency: r1 sends a=9, b=0xFFFFFFF3, op=100 with `MUL_LAT`=4. Expect `rsp_valid`=10 after the 4th edge following accept, `rsp_c`=0xFFFFFF8B.
- Backpressure: hold `rsp_ready`=00 for 5 cycles in RESP. Expect `rsp_valid`, `rsp_c`, `rsp_d` stable and `req_ready`=00 throughout. Assert `rsp_ready` on the non-owner bit only; expect no release.
- Fairness: r0 and r1 both continuously valid for 6 operations. Expect grants alternating r0, r1, r0, ... and `last` toggling each handshake.
- Reset mid-op: assert `rst` during the 2nd EXEC cycle of a mul. Expect immediate return to `rsp_valid`=00, `rsp_c`=0, `busy`=0, and no response afterwards. The next request is served normally.
